// File: rtl/del_scan_rx.sv
// Delay-configuration scan receiver: deserialises an NBITS vector on shift_clk and commits it to a shadow register.
// Selects change only on the edge that closes a full window while core_hold=1; there is no backpressure.
module del_scan_rx #(
  parameter int               NBITS     = 11,
  parameter logic [NBITS-1:0] RESET_VEC = '0
) (
  input  logic       shift_clk,
  input  logic       reset,
  input  logic       del_scan_en,
  input  logic       del_scan_in,
  input  logic       core_hold,
  output logic       del_scan_out,
  output logic [1:0] mem_delay_sel,
  output logic [1:0] ex_delay_sel,
  output logic [1:0] id_delay_sel,
  output logic [1:0] if_delay_sel,
  output logic [1:0] sram_lat_select,
  output logic       force_bare,
  output logic       cfg_valid,
  output logic       scan_err
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [3:0] CNT_FULL = 4'(NBITS);
  // One past full length marks an over-long window and is held there.
  localparam logic [3:0] CNT_MAX  = 4'(NBITS + 1);

  logic [0:0]       state;
  logic [NBITS-1:0] shift_reg;
  logic [NBITS-1:0] shadow;
  logic [3:0]       bit_cnt;
  logic [NBITS-1:0] shift_next;
  logic             window_close;
  logic             commit_ok;

  assign shift_next   = {shift_reg[NBITS-2:0], del_scan_in};
  assign window_close = (state == SHIFT) && !del_scan_en;
  assign commit_ok    = (bit_cnt == CNT_FULL) && core_hold;

  always_ff @(posedge shift_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (del_scan_en)  state <= SHIFT;
        SHIFT:   if (!del_scan_en) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The shift register keeps its contents after a window closes so it can be read back.
  always_ff @(posedge shift_clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
    end else if (del_scan_en) begin
      shift_reg <= shift_next;
    end
  end

  always_ff @(posedge shift_clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
    end else if (state == IDLE) begin
      if (del_scan_en) bit_cnt <= 4'd1;
    end else if (!del_scan_en) begin
      bit_cnt <= '0;
    end else if (bit_cnt != CNT_MAX) begin
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  always_ff @(posedge shift_clk or posedge reset) begin
    if (reset) begin
      shadow    <= RESET_VEC;
      cfg_valid <= 1'b0;
      scan_err  <= 1'b0;
    end else if (window_close) begin
      if (commit_ok) begin
        shadow    <= shift_reg;
        cfg_valid <= 1'b1;
        scan_err  <= 1'b0;
      end else begin
        scan_err  <= 1'b1;
      end
    end
  end

  assign del_scan_out    = shift_reg[NBITS-1];
  assign mem_delay_sel   = shadow[10:9];
  assign ex_delay_sel    = shadow[8:7];
  assign id_delay_sel    = shadow[6:5];
  assign if_delay_sel    = shadow[4:3];
  assign sram_lat_select = shadow[2:1];
  assign force_bare      = shadow[0];

endmodule

// File: tb/tb_del_scan_rx.sv
// Scoreboard bench for del_scan_rx: stimulus queues hand-computed expected outputs, a monitor pops and compares.
module tb_del_scan_rx;

  logic       shift_clk = 1'b0;
  logic       reset     = 1'b1;
  logic       del_scan_en = 1'b0;
  logic       del_scan_in = 1'b0;
  logic       core_hold   = 1'b0;
  logic       del_scan_out;
  logic [1:0] mem_delay_sel, ex_delay_sel, id_delay_sel, if_delay_sel, sram_lat_select;
  logic       force_bare, cfg_valid, scan_err;

  logic       clk_run = 1'b1;
  logic       probe   = 1'b0;
  logic [10:0] model_sr = '0;

  typedef struct {
    string       name;
    logic [13:0] v;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;

  del_scan_rx dut (
    .shift_clk      (shift_clk),
    .reset          (reset),
    .del_scan_en    (del_scan_en),
    .del_scan_in    (del_scan_in),
    .core_hold      (core_hold),
    .del_scan_out   (del_scan_out),
    .mem_delay_sel  (mem_delay_sel),
    .ex_delay_sel   (ex_delay_sel),
    .id_delay_sel   (id_delay_sel),
    .if_delay_sel   (if_delay_sel),
    .sram_lat_select(sram_lat_select),
    .force_bare     (force_bare),
    .cfg_valid      (cfg_valid),
    .scan_err       (scan_err)
  );

  initial forever begin
    #5;
    if (clk_run) shift_clk = ~shift_clk;
  end

  // Monitor: outputs only move on rising edges or reset, so negedge and probe instants are stable.
  initial forever begin
    exp_t        e;
    logic [13:0] act;
    @(negedge shift_clk or posedge probe);
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {del_scan_out, mem_delay_sel, ex_delay_sel, id_delay_sel, if_delay_sel,
             sram_lat_select, force_bare, cfg_valid, scan_err};
      total++;
      if (act === e.v) passed++;
      else $display("FAIL %s: got out/shadow/cfg/err=%b required %b", e.name, act, e.v);
    end
  end

  task automatic push_exp(input string nm, input logic [10:0] sh, input logic cv, input logic er);
    exp_t e;
    e.name = nm;
    e.v    = {model_sr[10], sh, cv, er};
    q.push_back(e);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge shift_clk);
      del_scan_en = 1'b1;
      del_scan_in = v[i];
      @(posedge shift_clk);
      model_sr = {model_sr[9:0], v[i]};
    end
  endtask

  task automatic close_win(input string nm, input logic hold, input logic [10:0] sh,
                           input logic cv, input logic er);
    @(negedge shift_clk);
    del_scan_en = 1'b0;
    del_scan_in = 1'b0;
    core_hold   = hold;
    @(posedge shift_clk);
    #1;
    push_exp(nm, sh, cv, er);
  endtask

  task automatic probe_now(input string nm, input logic [10:0] sh, input logic cv, input logic er);
    push_exp(nm, sh, cv, er);
    probe = 1'b1;
    #1;
    probe = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    @(posedge shift_clk);
    #2;
    reset = 1'b1;
    #1;
    model_sr = '0;
    probe_now(nm, 11'b0, 1'b0, 1'b0);
    @(negedge shift_clk);
    reset = 1'b0;
  endtask

  initial begin
    #2;
    probe_now("reset_state", 11'b0, 1'b0, 1'b0);
    @(negedge shift_clk);
    reset = 1'b0;

    // Idle edges with en low and data toggling must not change anything.
    for (int i = 0; i < 3; i++) begin
      @(negedge shift_clk);
      del_scan_in = ~del_scan_in;
    end
    @(posedge shift_clk);
    #1;
    push_exp("zero_length_window", 11'b0, 1'b0, 1'b0);

    // 1: full valid scan; selects must not move before the en-low edge.
    send_bits(16'b111_1111_1000, 11);
    #1;
    push_exp("t1_before_commit", 11'b0, 1'b0, 1'b0);
    close_win("t1_commit", 1'b1, 11'b111_1111_1000, 1'b1, 1'b0);

    // 2: short, over-long, then good window.
    send_bits(16'h03FF, 10);
    close_win("t2_short_10", 1'b1, 11'b111_1111_1000, 1'b1, 1'b1);
    send_bits(16'h0FFF, 12);
    close_win("t2_long_12", 1'b1, 11'b111_1111_1000, 1'b1, 1'b1);
    send_bits(16'b000_0000_0001, 11);
    close_win("t2_good_force_bare", 1'b1, 11'b000_0000_0001, 1'b1, 1'b0);

    // 3: valid length but controllers not held.
    do_reset("t3_reset");
    send_bits(16'b101_0101_0101, 11);
    close_win("t3_no_hold", 1'b0, 11'b0, 1'b0, 1'b1);

    // 4: asynchronous reset mid-window with the clock stopped.
    send_bits(16'b111_1111_1111, 6);
    @(negedge shift_clk);
    clk_run = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_sr = '0;
    probe_now("t4_async_reset", 11'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    del_scan_en = 1'b0;
    clk_run = 1'b1;
    send_bits(16'b111_1111_1000, 11);
    close_win("t4_after_reset", 1'b1, 11'b111_1111_1000, 1'b1, 1'b0);

    // 5: back-to-back windows, one en-low edge between them.
    send_bits(16'b000_0000_0011, 11);
    close_win("t5_first", 1'b1, 11'b000_0000_0011, 1'b1, 1'b0);
    send_bits(16'b110_0000_0000, 11);
    close_win("t5_second", 1'b1, 11'b110_0000_0000, 1'b1, 1'b0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge shift_clk);
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expected responses never compared, required 0", q.size());
      total += q.size();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
